// File: rtl/kb_pkg.sv
// rtl/kb_pkg.sv - shared constants and types for the keyboard event path
//
// Purpose: scancode constants, decoder state encoding and queue entry width
// shared by kb_key_sequencer and kb_event_fifo users.
// Ports: none (package).

package kb_pkg;

  localparam logic [7:0] SC_BREAK      = 8'hF0;
  localparam logic [7:0] SC_EXT        = 8'hE0;
  localparam logic [7:0] SC_LSHIFT     = 8'h12;
  localparam logic [7:0] SC_RSHIFT     = 8'h59;
  localparam logic [7:0] SC_CAPS       = 8'h58;
  // Bytes at or above this value (other than E0/F0) are receiver/protocol
  // chatter (AA, FA, FE, EE, E1) rather than key codes.
  localparam logic [7:0] SC_IGNORE_MIN = 8'h84;

  // Queue entry layout: {shift, capslock, scancode[7:0]}
  localparam int ENTRY_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kb_state_e;

endpackage

// File: rtl/kb_event_fifo.sv
// rtl/kb_event_fifo.sv - small synchronous FIFO for keyboard events
//
// Purpose: DEPTH x WIDTH queue with registered storage and no fall-through.
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise it is silently dropped (the caller flags overflow).
// Ports:
//   clk         - clock, rising edge
//   rst_n_i     - asynchronous active-low reset, empties the queue
//   push_i      - write push_data_i at the tail
//   push_data_i - entry to write
//   pop_i       - consume the head entry (ignored when empty)
//   pop_data_o  - head entry, zero while empty
//   full_o      - DEPTH entries held
//   empty_o     - no entries held
//   count_o     - occupancy 0..DEPTH

module kb_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign count_o = count_q;

  // Full + simultaneous pop frees a slot, so the push is still taken.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Head is gated so an empty queue presents all zeros, not stale data.
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth: pointers wrap by natural overflow.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/kb_key_sequencer.sv
// rtl/kb_key_sequencer.sv - PS/2 scancode decoder, modifier tracker, make queue
//
// Purpose: decodes make / F0 break / E0 extended sequences, tracks shift and
// capslock, and queues printable make codes tagged with the modifier state
// seen before the byte arrived.
// Ports:
//   clk              - clock, rising edge
//   i_rst_n          - asynchronous active-low reset
//   i_scancode       - byte from PS/2 receiver
//   i_scancode_valid - one-cycle strobe qualifying i_scancode
//   i_ready          - translator accepts head entry
//   i_ovf_clr        - clears o_overflow
//   o_valid          - queue non-empty
//   o_scancode       - head scancode
//   o_shift          - head shift tag
//   o_capslock       - head capslock tag
//   o_shift_held     - live left|right shift
//   o_capslock_on    - live capslock toggle
//   o_count          - queue occupancy
//   o_overflow       - sticky: a make was dropped on a full queue

module kb_key_sequencer
  import kb_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 65536
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic [7:0]             i_scancode,
  input  logic                   i_scancode_valid,
  input  logic                   i_ready,
  input  logic                   i_ovf_clr,
  output logic                   o_valid,
  output logic [7:0]             o_scancode,
  output logic                   o_shift,
  output logic                   o_capslock,
  output logic                   o_shift_held,
  output logic                   o_capslock_on,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow
);

  localparam int                TMO_W    = $clog2(TIMEOUT) + 1;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  kb_state_e        state_q, state_d;
  logic             lshift_q, lshift_d;
  logic             rshift_q, rshift_d;
  logic             caps_held_q, caps_held_d;
  logic             caps_on_q, caps_on_d;
  logic             ovf_q, ovf_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head;

  assign o_shift_held  = lshift_q | rshift_q;
  assign o_capslock_on = caps_on_q;
  assign o_valid       = !empty;
  assign o_scancode    = head[7:0];
  assign o_capslock    = head[8];
  assign o_shift       = head[9];
  assign o_overflow    = ovf_q;
  assign pop           = o_valid && i_ready;

  // Tag uses registered modifiers, i.e. the state before this byte.
  assign push_data = {lshift_q | rshift_q, caps_on_q, i_scancode};

  always_comb begin
    state_d     = state_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_held_d = caps_held_q;
    caps_on_d   = caps_on_q;
    tmo_d       = '0;
    push        = 1'b0;

    if (i_scancode_valid) begin
      if (i_scancode == SC_EXT) begin
        state_d = ST_EXT;
      end else if (i_scancode == SC_BREAK) begin
        state_d = (state_q == ST_IDLE || state_q == ST_BRK) ? ST_BRK : ST_EXT_BRK;
      end else if (i_scancode >= SC_IGNORE_MIN) begin
        state_d = state_q;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (i_scancode == SC_LSHIFT) begin
              lshift_d = 1'b1;
            end else if (i_scancode == SC_RSHIFT) begin
              rshift_d = 1'b1;
            end else if (i_scancode == SC_CAPS) begin
              // Typematic repeats of caps must not re-toggle.
              if (!caps_held_q) begin
                caps_on_d   = !caps_on_q;
                caps_held_d = 1'b1;
              end
            end else begin
              push = 1'b1;
            end
          end
          ST_BRK: begin
            if (i_scancode == SC_LSHIFT) lshift_d    = 1'b0;
            if (i_scancode == SC_RSHIFT) rshift_d    = 1'b0;
            if (i_scancode == SC_CAPS)   caps_held_d = 1'b0;
            state_d = ST_IDLE;
          end
          default: begin
            // Extended make/break (incl. fake shift E0 12): discarded.
            state_d = ST_IDLE;
          end
        endcase
      end
    end else if (state_q != ST_IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d = ST_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // Set beats clear when both happen in one cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (i_ovf_clr) ovf_d = 1'b0;
    if (push && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_held_q <= 1'b0;
      caps_on_q   <= 1'b0;
      ovf_q       <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_held_q <= caps_held_d;
      caps_on_q   <= caps_on_d;
      ovf_q       <= ovf_d;
      tmo_q       <= tmo_d;
    end
  end

  kb_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n_i     (i_rst_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .pop_data_o  (head),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (o_count)
  );

endmodule

// File: tb/tb_kb_key_sequencer.sv
// tb/tb_kb_key_sequencer.sv - directed table-driven bench for kb_key_sequencer

module tb_kb_key_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic [7:0] i_scancode;
  logic       i_scancode_valid;
  logic       i_ready;
  logic       i_ovf_clr;
  logic       o_valid;
  logic [7:0] o_scancode;
  logic       o_shift;
  logic       o_capslock;
  logic       o_shift_held;
  logic       o_capslock_on;
  logic [2:0] o_count;
  logic       o_overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  kb_key_sequencer #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .i_rst_n          (i_rst_n),
    .i_scancode       (i_scancode),
    .i_scancode_valid (i_scancode_valid),
    .i_ready          (i_ready),
    .i_ovf_clr        (i_ovf_clr),
    .o_valid          (o_valid),
    .o_scancode       (o_scancode),
    .o_shift          (o_shift),
    .o_capslock       (o_capslock),
    .o_shift_held     (o_shift_held),
    .o_capslock_on    (o_capslock_on),
    .o_count          (o_count),
    .o_overflow       (o_overflow)
  );

  typedef struct {
    logic [7:0] code;
    logic       v;
    logic [7:0] sc;
    logic       sh;
    logic       cp;
    logic       held;
    logic       on;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [7:0] code, input logic v, input logic [7:0] sc,
                              input logic sh, input logic cp, input logic held,
                              input logic on, input logic [2:0] cnt);
    vec_t r;
    r.code = code; r.v = v; r.sc = sc; r.sh = sh; r.cp = cp;
    r.held = held; r.on = on; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at a negedge; the byte is sampled at the next posedge and the
  // task returns on the following negedge, where results are visible.
  task automatic send(input logic [7:0] b);
    i_scancode       = b;
    i_scancode_valid = 1'b1;
    @(negedge clk);
    i_scancode_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] drain_exp [4];

  initial begin
    i_rst_n          = 1'b0;
    i_scancode       = 8'h00;
    i_scancode_valid = 1'b0;
    i_ready          = 1'b1;
    i_ovf_clr        = 1'b0;

    // make/break basic
    vecs.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 0, 0, 1));
    vecs.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'h1C, 0, 8'h00, 0, 0, 0, 0, 0));
    // left shift tagging
    vecs.push_back(mk(8'h12, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(8'h1C, 1, 8'h1C, 1, 0, 1, 0, 1));
    vecs.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(8'h12, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 0, 0, 1));
    // capslock with typematic repeats
    vecs.push_back(mk(8'h58, 0, 8'h00, 0, 0, 0, 1, 0));
    vecs.push_back(mk(8'h58, 0, 8'h00, 0, 0, 0, 1, 0));
    vecs.push_back(mk(8'h58, 0, 8'h00, 0, 0, 0, 1, 0));
    vecs.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 0, 1, 0));
    vecs.push_back(mk(8'h58, 0, 8'h00, 0, 0, 0, 1, 0));
    vecs.push_back(mk(8'h15, 1, 8'h15, 0, 1, 0, 1, 1));
    vecs.push_back(mk(8'h58, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'h58, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'h58, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'h58, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'h15, 1, 8'h15, 0, 0, 0, 0, 1));
    // extended keys and ignored bytes
    vecs.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'h75, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'h75, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'h12, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'hAA, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 0, 0, 1));
    // right shift, fake-shift release must not clear it
    vecs.push_back(mk(8'h59, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(8'h12, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(8'h12, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(8'h1C, 1, 8'h1C, 1, 0, 1, 0, 1));
    vecs.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(8'h59, 0, 8'h00, 0, 0, 0, 0, 0));
    // ignored byte inside a break sequence keeps BRK
    vecs.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'hAA, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'h1C, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 0, 0, 1));

    // reset state
    idle(2);
    chk("reset_outputs",
        {o_valid, o_scancode, o_shift, o_capslock, o_count, o_overflow, o_shift_held, o_capslock_on},
        '0);
    i_rst_n = 1'b1;
    idle(1);

    // table
    foreach (vecs[i]) begin
      send(vecs[i].code);
      chk($sformatf("vec%0d_ctl", i), {o_valid, o_count, o_shift_held, o_capslock_on},
          {vecs[i].v, vecs[i].cnt, vecs[i].held, vecs[i].on});
      if (vecs[i].v)
        chk($sformatf("vec%0d_head", i), {o_scancode, o_shift, o_capslock},
            {vecs[i].sc, vecs[i].sh, vecs[i].cp});
    end
    idle(1);
    chk("drained_after_table", {o_valid, o_count}, 4'b0);

    // fill, overflow, stable head while stalled
    i_ready = 1'b0;
    send(8'h16); chk("fill1", {o_count, o_scancode, o_overflow}, {3'd1, 8'h16, 1'b0});
    send(8'h1E); chk("fill2", {o_count, o_scancode, o_overflow}, {3'd2, 8'h16, 1'b0});
    send(8'h26); chk("fill3", {o_count, o_scancode, o_overflow}, {3'd3, 8'h16, 1'b0});
    send(8'h25); chk("fill4", {o_count, o_scancode, o_overflow}, {3'd4, 8'h16, 1'b0});
    send(8'h2E); chk("ovf_set", {o_valid, o_count, o_scancode, o_overflow}, {1'b1, 3'd4, 8'h16, 1'b1});
    i_ovf_clr = 1'b1; idle(1); i_ovf_clr = 1'b0;
    chk("ovf_clr", {o_overflow, o_count}, {1'b0, 3'd4});
    // set and clear in the same cycle: set wins
    i_ovf_clr = 1'b1; send(8'h3D); i_ovf_clr = 1'b0;
    chk("ovf_set_beats_clr", {o_overflow, o_count}, {1'b1, 3'd4});
    i_ovf_clr = 1'b1; idle(1); i_ovf_clr = 1'b0;
    chk("ovf_clr2", o_overflow, 1'b0);
    // push and pop on a full queue both succeed
    i_ready = 1'b1;
    send(8'h36);
    chk("full_push_pop", {o_count, o_overflow, o_scancode}, {3'd4, 1'b0, 8'h1E});
    drain_exp[0] = 8'h1E; drain_exp[1] = 8'h26; drain_exp[2] = 8'h25; drain_exp[3] = 8'h36;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d", k), {o_valid, o_scancode}, {1'b1, drain_exp[k]});
      idle(1);
    end
    chk("drain_empty", {o_valid, o_count}, 4'b0);

    // prefix timeout boundary, modifiers kept across timeout
    send(8'h12);
    send(8'hF0);
    idle(TIMEOUT - 1);
    send(8'h1C);
    chk("tmo_minus1_is_release", {o_valid, o_shift_held}, 2'b01);
    send(8'hF0);
    idle(TIMEOUT);
    send(8'h1C);
    chk("tmo_then_make", {o_valid, o_scancode, o_shift, o_capslock, o_shift_held},
        {1'b1, 8'h1C, 1'b1, 1'b0, 1'b1});
    send(8'hF0);
    send(8'h12);
    chk("tmo_shift_released", {o_valid, o_shift_held}, 2'b00);

    // asynchronous reset mid-sequence
    i_ready = 1'b0;
    send(8'h12);
    send(8'h1C);
    send(8'h58);
    send(8'hF0);
    chk("pre_reset", {o_count, o_shift_held, o_capslock_on}, {3'd1, 1'b1, 1'b1});
    #1 i_rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {o_valid, o_scancode, o_shift, o_capslock, o_count, o_overflow, o_shift_held, o_capslock_on},
        '0);
    @(negedge clk);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    send(8'h1C);
    chk("post_reset_make", {o_valid, o_scancode, o_shift, o_capslock, o_count, o_shift_held, o_capslock_on},
        {1'b1, 8'h1C, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kb_key_sequencer.md
# kb_key_sequencer

Keyboard event controller between the PS/2 byte receiver and the scancode-to-ASCII translator. Decodes the raw byte stream (make, `F0` break prefix, `E0` extended prefix) and tracks shift and capslock state. Queues printable make events, tagged with the modifier state at key-down, in a small FIFO. The translator drains the FIFO through a valid/ready handshake, so it only ever sees clean make codes with their modifiers.

## Interface
- `DEPTH`, 4: FIFO entries; must be a power of 2.
- `TIMEOUT`, 65536: idle cycles after a prefix byte before the decoder abandons the sequence.
- `clk` in 1: clock, rising edge.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_scancode` in 8: byte from the PS/2 receiver.
- `i_scancode_valid` in 1: one-cycle strobe qualifying `i_scancode`.
- `i_ready` in 1: translator accepts the head entry.
- `i_ovf_clr` in 1: clears `o_overflow`.
- `o_valid` out 1: FIFO non-empty.
- `o_scancode` out 8: head entry scancode.
- `o_shift` out 1: head entry shift tag.
- `o_capslock` out 1: head entry capslock tag.
- `o_shift_held` out 1: live value, left shift OR right shift.
- `o_capslock_on` out 1: live capslock toggle.
- `o_count` out clog2(DEPTH)+1: FIFO occupancy.
- `o_overflow` out 1: sticky flag; a make event was dropped because the FIFO was full.

## Operation
- Decoder FSM states: `IDLE`, `BRK` (after `F0`), `EXT` (after `E0`), `EXT_BRK` (after `E0 F0`). It advances only on cycles where `i_scancode_valid` is high.
- `E0` in any state goes to `EXT`.
- `F0` in `IDLE` or `BRK` goes to `BRK`; `F0` in `EXT` or `EXT_BRK` goes to `EXT_BRK`.
- Bytes `>= 8'h84`, other than `E0`/`F0`, are ignored with no state change. This covers `AA`, `FA`, `FE`, `EE`, `E1`.
- Any other byte `c` in `IDLE` is a make:
  - `12` sets lshift; `59` sets rshift.
  - `58`: if `caps_held` is clear, toggle capslock and set `caps_held`; if it is already set, do nothing (typematic repeat).
  - Any other `c` pushes `{shift_held, capslock_on, c}`. Typematic repeats push again.
  - State stays `IDLE`.
- Byte `c` in `BRK` is a release, then go to `IDLE`: `12` clears lshift, `59` clears rshift, `58` clears `caps_held`. Nothing is pushed.
- Byte `c` in `EXT` or `EXT_BRK`: go to `IDLE`. Extended keys (including the fake shift `E0 12`) are discarded and modifiers are unchanged.
- Push while full with no pop in the same cycle: entry dropped and `o_overflow` set. `o_overflow` clears on `i_ovf_clr`; a set in the same cycle as the clear wins.
- Timeout: a counter resets on every valid byte. In a non-`IDLE` state, after `TIMEOUT` consecutive cycles without a valid byte, return to `IDLE` with modifiers unchanged.

## Timing
- Reset values: FSM `IDLE`; lshift, rshift, `caps_held`, `capslock_on` all 0; FIFO empty. Outputs: `o_valid` 0, `o_scancode` 8'h00, `o_shift` 0, `o_capslock` 0, `o_count` 0, `o_overflow` 0, `o_shift_held` 0, `o_capslock_on` 0.
- Modifier tag: the value latched before the current byte.
- Latency:
  - Valid byte at edge N: `o_valid` and head data update at N+1.
  - Modifier and capslock changes are visible at N+1.
  - There is no fall-through path.
- Handshake:
  - A pop occurs on a cycle where `o_valid && i_ready`.
  - Head data is stable while `o_valid && !i_ready`.
- Simultaneous push and pop:
  - When full: both succeed, count unchanged, no overflow.
  - When empty: push only.
- Pointers wrap modulo `DEPTH`. `o_count` ranges 0..`DEPTH`.
- Reset asserted mid-sequence (for example after `F0`) aborts the sequence and flushes the FIFO immediately (asynchronous).

## Structure
- `kb_pkg` holds:
  - Scancode constants `SC_BREAK` 8'hF0, `SC_EXT` 8'hE0, `SC_LSHIFT` 8'h12, `SC_RSHIFT` 8'h59, `SC_CAPS` 8'h58.
  - The decoder state encoding.
  - The entry width constant (10).
- Sub-module `kb_event_fifo`: synchronous FIFO parameterised by `DEPTH` and width, with push/pop, full/empty, count. It is reused for the translator output queue.
- The FSM, modifier registers and timeout counter live in `kb_key_sequencer`.

## Test plan
- Send `1C` with `i_ready`=1: one entry `{0,0,1C}`, `o_valid` for one cycle. Then `F0 1C`: no entry.
- Send `12`, `1C`, `F0 12`, `1C`: entries `{1,0,1C}` then `{0,0,1C}`; `o_shift_held` is 1 for the middle interval.
- Send `58 58 58 F0 58`, then `15`: `o_capslock_on`=1 (single toggle), entry `{0,1,15}`. Repeat the sequence: `o_capslock_on`=0.
- Send `E0 75`, `E0 F0 75`, `E0 12`, `AA`: no entries, modifiers unchanged, FSM back in `IDLE`.
- With `i_ready`=0, send 5 makes (`16 1E 26 25 2E`): `o_count`=4, `o_overflow`=1, head `16`. Drain with `i_ready`=1: `16 1E 26 25` in order. Pulse `i_ovf_clr`: `o_overflow`=0.
- Send `F0`, wait `TIMEOUT` cycles, send `1C`: entry `{0,0,1C}` pushed. Separately, assert `i_rst_n`=0 after `F0`: all outputs return to reset values.
